median_stream_source: RTL



---
 rtl/median_stream_source.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/median_stream_source.sv
// Transmit end of the median pipeline FIFO protocol: buffers one pixel window,
// emits the first-stage header tokens (pivot, size, median position, second
// median), then streams the buffered pixels into the pixel FIFO.
module median_stream_source #(
    parameter int unsigned BUFF_SIZE     = 1024,
    parameter int unsigned BUFF_SIZE_BIT = 16,
    parameter logic [7:0]  DEFAULT_PIVOT = 8'd127
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               load_px,
    input  logic                     load_valid,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic [7:0]               out_px,
    output logic                     out_px_wr,
    input  logic                     out_px_full,
    output logic [7:0]               out_pivot,
    output logic                     out_pivot_wr,
    input  logic                     out_pivot_full,
    output logic [BUFF_SIZE_BIT-1:0] out_buff_size,
    output logic                     out_buff_size_wr,
    input  logic                     out_buff_size_full,
    output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
    output logic                     out_median_pos_wr,
    input  logic                     out_median_pos_full,
    output logic [7:0]               out_second_median_value,
    output logic                     out_second_median_value_wr,
    input  logic                     out_second_median_value_full,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned AddrW = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1;
    localparam logic [BUFF_SIZE_BIT-1:0] MaxLen = BUFF_SIZE_BIT'(BUFF_SIZE);

    typedef enum logic [1:0] {StLoad, StHdr, StSend} state_e;

    state_e                   state_q, state_d;
    logic [BUFF_SIZE_BIT-1:0] len_q, len_d, idx_q, idx_d;
    logic [BUFF_SIZE_BIT-1:0] size_q, size_d, mpos_q, mpos_d;
    logic [BUFF_SIZE_BIT-1:0] len_inc;
    logic [3:0]               done_q, done_d;
    logic [3:0]               hdr_full, hdr_wr;
    logic [7:0]               min_q, min_d, max_q, max_d;
    logic [7:0]               min_new, max_new, pivot_calc;
    logic [7:0]               pivot_q, pivot_d, second_q, second_d;
    logic [8:0]               sum9;
    logic                     frame_done_q, frame_done_d;
    logic                     px_wr;
    logic [7:0]               mem [BUFF_SIZE];

    // Header FIFO order in the flag vector: pivot, size, median pos, second median.
    assign hdr_full = {out_second_median_value_full, out_median_pos_full,
                       out_buff_size_full, out_pivot_full};

    // Next-state, handshakes and header parameter latch.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        done_d       = done_q;
        min_d        = min_q;
        max_d        = max_q;
        pivot_d      = pivot_q;
        second_d     = second_q;
        size_d       = size_q;
        mpos_d       = mpos_q;
        frame_done_d = 1'b0;
        load_ready   = 1'b0;
        hdr_wr       = 4'b0000;
        px_wr        = 1'b0;

        // Running extrema including the pixel on the port, so the final
        // accept's parameters account for that pixel.
        min_new    = (load_px < min_q) ? load_px : min_q;
        max_new    = (load_px > max_q) ? load_px : max_q;
        sum9       = {1'b0, min_new} + {1'b0, max_new};
        pivot_calc = (min_new > max_new) ? DEFAULT_PIVOT : sum9[8:1];
        len_inc    = len_q + 1'b1;

        unique case (state_q)
            StLoad: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    len_d = len_inc;
                    min_d = min_new;
                    max_d = max_new;
                    // A full buffer ends the window even without load_last.
                    if (load_last || (len_inc == MaxLen)) begin
                        state_d  = StHdr;
                        pivot_d  = pivot_calc;
                        second_d = pivot_calc;
                        size_d   = len_inc;
                        mpos_d   = len_inc >> 1;
                    end
                end
            end
            StHdr: begin
                hdr_wr = ~done_q & ~hdr_full;
                done_d = done_q | hdr_wr;
                if (&done_d) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                px_wr = ~out_px_full;
                if (px_wr) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        state_d      = StLoad;
                        len_d        = '0;
                        idx_d        = '0;
                        done_d       = 4'b0000;
                        min_d        = 8'hFF;
                        max_d        = 8'h00;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Control and header registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StLoad;
            len_q        <= '0;
            idx_q        <= '0;
            done_q       <= 4'b0000;
            min_q        <= 8'hFF;
            max_q        <= 8'h00;
            pivot_q      <= 8'h00;
            second_q     <= 8'h00;
            size_q       <= '0;
            mpos_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            done_q       <= done_d;
            min_q        <= min_d;
            max_q        <= max_d;
            pivot_q      <= pivot_d;
            second_q     <= second_d;
            size_q       <= size_d;
            mpos_q       <= mpos_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pixel buffer write on each accept; contents need no reset.
    always_ff @(posedge clock) begin
        if (!reset && (state_q == StLoad) && load_valid) begin
            mem[len_q[AddrW-1:0]] <= load_px;
        end
    end

    assign out_px                     = (state_q == StSend) ? mem[idx_q[AddrW-1:0]] : 8'h00;
    assign out_px_wr                  = px_wr;
    assign out_pivot                  = pivot_q;
    assign out_pivot_wr               = hdr_wr[0];
    assign out_buff_size              = size_q;
    assign out_buff_size_wr           = hdr_wr[1];
    assign out_median_pos             = mpos_q;
    assign out_median_pos_wr          = hdr_wr[2];
    assign out_second_median_value    = second_q;
    assign out_second_median_value_wr = hdr_wr[3];
    assign busy                       = (state_q != StLoad);
    assign frame_done                 = frame_done_q;

endmodule
